uart_tx_cfg: RTL and testbench

//   Parametrised UART transmitter: next generation of uart_tx. Serialises one DATA_BITS-wide word per

---
 rtl/uart_tx_cfg.sv | 157 +++++++++++++++
 tb/tb_uart_tx_cfg.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start + DATA_BITS (LSB first) + optional parity + 1/2 stop bits.
// Baud divider, frame latch and FSM share one clock and one synchronous active-high reset.
module uart_tx_cfg #(
   parameter int unsigned UART_INPUT_CLK = 100_000_000,
   parameter int unsigned BAUD_RATE      = 9600,
   parameter int unsigned DATA_BITS      = 8,
   parameter int unsigned PARITY_MODE    = 0,
   parameter int unsigned STOP_BITS      = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_en,
   input  logic [DATA_BITS-1:0] data_in,
   output logic                 tx,
   output logic                 done,
   output logic                 busy
);

   localparam int unsigned DIV   = UART_INPUT_CLK / BAUD_RATE;
   localparam int unsigned BaudW = (DIV < 2) ? 1 : $clog2(DIV);
   localparam int unsigned BitW  = (DATA_BITS < 2) ? 1 : $clog2(DATA_BITS);

   localparam logic [BaudW-1:0] BaudLast = BaudW'(DIV - 1);
   localparam logic [BitW-1:0]  DataLast = BitW'(DATA_BITS - 1);
   localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);

   if (DIV < 2) begin : g_bad_div
      $error("uart_tx_cfg: UART_INPUT_CLK/BAUD_RATE must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_cfg: DATA_BITS must be 5..9");
   end
   if (PARITY_MODE > 2) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY_MODE must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e                 state_q, state_d;
   logic [BaudW-1:0]       baud_q, baud_d;
   logic [BitW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   par_q, par_d;
   logic                   tx_q, tx_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   baud_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      par_d     = par_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      baud_last = (baud_q == BaudLast);

      // Baud counter free-runs in every bit state and wraps on its terminal count.
      if (state_q != StIdle) begin
         baud_d = baud_last ? '0 : baud_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (tx_en) begin
               state_d = StStart;
               shift_d = data_in;
               par_d   = (PARITY_MODE == 1) ? ~^data_in : ^data_in;
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         StStart: begin
            if (baud_last) begin
               state_d = StData;
               bit_d   = '0;
               tx_d    = shift_q[0];
            end
         end
         StData: begin
            if (baud_last) begin
               if (bit_q == DataLast) begin
                  bit_d = '0;
                  if (PARITY_MODE != 0) begin
                     state_d = StParity;
                     tx_d    = par_q;
                  end else begin
                     state_d = StStop;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end
         end
         StParity: begin
            if (baud_last) begin
               state_d = StStop;
               tx_d    = 1'b1;
            end
         end
         StStop: begin
            // bit_q counts stop bits here so two stop bits reuse the same counter.
            if (baud_last) begin
               if (bit_q == StopLast) begin
                  state_d = StIdle;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign tx   = tx_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: three framing variants (8N1, 7E2, 7O2) at DIV=4, checked cycle by cycle
// against a bit-list frame model.
module tb_uart_tx_cfg;

   localparam int unsigned InClk = 400;
   localparam int unsigned Baud  = 100;
   localparam int          Div   = 4;

   logic       clk;
   logic [2:0] rst_v, en_v, tx_v, done_v, busy_v;
   logic [8:0] din_a [3];

   int n_vec = 0;
   int n_err = 0;

   int dbits [3] = '{8, 7, 7};
   int pmode [3] = '{0, 2, 1};
   int nstop [3] = '{1, 2, 2};

   uart_tx_cfg #(
      .UART_INPUT_CLK(InClk), .BAUD_RATE(Baud), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)
   ) u_dut_8n1 (
      .clk(clk), .rst(rst_v[0]), .tx_en(en_v[0]), .data_in(din_a[0][7:0]),
      .tx(tx_v[0]), .done(done_v[0]), .busy(busy_v[0])
   );

   uart_tx_cfg #(
      .UART_INPUT_CLK(InClk), .BAUD_RATE(Baud), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)
   ) u_dut_7e2 (
      .clk(clk), .rst(rst_v[1]), .tx_en(en_v[1]), .data_in(din_a[1][6:0]),
      .tx(tx_v[1]), .done(done_v[1]), .busy(busy_v[1])
   );

   uart_tx_cfg #(
      .UART_INPUT_CLK(InClk), .BAUD_RATE(Baud), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)
   ) u_dut_7o2 (
      .clk(clk), .rst(rst_v[2]), .tx_en(en_v[2]), .data_in(din_a[2][6:0]),
      .tx(tx_v[2]), .done(done_v[2]), .busy(busy_v[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // Expected per-cycle tx/busy/done, cycle 0 being the first start-bit cycle.
   // Cycles after 'cut' (when >= 0) are idle because of a reset.
   function automatic void model(input int idx, input logic [8:0] d, input int n, input int cut,
                                 output logic [63:0] et, output logic [63:0] eb,
                                 output logic [63:0] ed);
      logic bits [$];
      int   ones;
      int   frame;
      ones = 0;
      bits.push_back(1'b0);
      for (int i = 0; i < dbits[idx]; i++) begin
         bits.push_back(d[i]);
         if (d[i]) ones++;
      end
      if (pmode[idx] == 2) bits.push_back(ones % 2 == 1);
      else if (pmode[idx] == 1) bits.push_back(ones % 2 == 0);
      for (int s = 0; s < nstop[idx]; s++) bits.push_back(1'b1);
      frame = bits.size() * Div;
      et = '0;
      eb = '0;
      ed = '0;
      for (int c = 0; c < n; c++) begin
         if (cut >= 0 && c > cut) begin
            et[c] = 1'b1;
         end else if (c < frame) begin
            et[c] = bits[c / Div];
            eb[c] = 1'b1;
         end else begin
            et[c] = 1'b1;
            ed[c] = (c == frame);
         end
      end
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge of frame cycle 0.
   task automatic start(input int idx, input logic [8:0] d);
      din_a[idx] = d;
      en_v[idx]  = 1'b1;
      @(negedge clk);
      en_v[idx]  = 1'b0;
   endtask

   // ev_kind: 0 none, 1 one-cycle tx_en pulse at ev_at, 2 one-cycle rst at ev_at.
   task automatic grab(input int idx, input int n, input int ev_at, input int ev_kind,
                       input logic [8:0] cur, input logic [8:0] nxt, input string tag,
                       output int bcnt);
      logic [63:0] tv, bv, dv, et, eb, ed;
      tv = '0;
      bv = '0;
      dv = '0;
      for (int c = 0; c < n; c++) begin
         tv[c] = tx_v[idx];
         bv[c] = busy_v[idx];
         dv[c] = done_v[idx];
         if (c == 1) din_a[idx] = nxt;
         if (ev_kind == 1 && c == ev_at) en_v[idx] = 1'b1;
         if (ev_kind == 1 && c == ev_at + 1) en_v[idx] = 1'b0;
         if (ev_kind == 2 && c == ev_at) rst_v[idx] = 1'b1;
         if (ev_kind == 2 && c == ev_at + 1) rst_v[idx] = 1'b0;
         @(negedge clk);
      end
      model(idx, cur, n, (ev_kind == 2) ? ev_at : -1, et, eb, ed);
      check_val({tag, ".tx"}, tv, et);
      check_val({tag, ".busy"}, bv, eb);
      check_val({tag, ".done"}, dv, ed);
      bcnt = $countones(bv);
   endtask

   initial begin
      int         bcnt;
      int         idx;
      logic [8:0] d;

      rst_v    = 3'b111;
      en_v     = 3'b001;
      din_a[0] = 9'h0A5;
      din_a[1] = 9'h000;
      din_a[2] = 9'h000;

      // Reset held with tx_en high: line idle, nothing starts.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            check_val($sformatf("reset%0d.dut%0d", k, i),
                      {61'd0, tx_v[i], busy_v[i], done_v[i]}, 64'd4);
         end
      end
      rst_v = 3'b000;
      @(negedge clk);
      en_v[0] = 1'b0;
      grab(0, 43, -1, 0, 9'h0A5, 9'($urandom), "8n1_a5", bcnt);
      check_val("8n1_busy_len", 64'(bcnt), 64'd40);

      start(1, 9'h055);
      grab(1, 47, -1, 0, 9'h055, 9'($urandom), "7e2_55", bcnt);
      check_val("7e2_busy_len", 64'(bcnt), 64'd44);
      start(2, 9'h055);
      grab(2, 47, -1, 0, 9'h055, 9'($urandom), "7o2_55", bcnt);
      check_val("7o2_busy_len", 64'(bcnt), 64'd44);

      // Back-to-back with tx_en held; data_in changes to the second word mid-frame.
      din_a[0] = 9'h001;
      en_v[0]  = 1'b1;
      @(negedge clk);
      grab(0, 41, -1, 0, 9'h001, 9'h0FF, "b2b_first", bcnt);
      en_v[0] = 1'b0;
      grab(0, 43, -1, 0, 9'h0FF, 9'($urandom), "b2b_second", bcnt);

      d = 9'($urandom);
      start(0, d);
      grab(0, 43, 10, 1, d, 9'($urandom), "busy_ignore", bcnt);

      d = 9'($urandom);
      start(0, d);
      grab(0, 43, 17, 2, d, 9'($urandom), "mid_reset", bcnt);
      d = 9'($urandom);
      start(0, d);
      grab(0, 43, -1, 0, d, 9'($urandom), "post_reset", bcnt);

      for (int r = 0; r < 8; r++) begin
         idx = int'($urandom_range(0, 2));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         d = 9'($urandom);
         start(idx, d);
         grab(idx, (idx == 0) ? 43 : 47, -1, 0, d, 9'($urandom), $sformatf("rand%0d", r), bcnt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
